// File: rtl/traffic_light_conflict_monitor.sv
// Safety observer for the two-intersection lamp controller.
// Ports: clk_50_mhz/reset, 12 vehicle + 8 crossing lamp inputs,
// fault_clear in; armed, fault, fault_code, fault_src, fault_pulse,
// fault_cnt out. Approach index: 0 nrth_s10th, 1 west_s10th,
// 2 nrth_s11th, 3 west_s11th. Codes: 1 triple not one-hot,
// 2 north/west both non-red, 3 illegal step, 4 short yellow,
// 5 crossing walk==stop, 6 walk against traffic.
module traffic_light_conflict_monitor #(
  parameter int MIN_YLW_CYCLES = 100,
  parameter int YLW_CNT_W      = 16
) (
  input  logic       clk_50_mhz,
  input  logic       reset,
  input  logic       red_nrth_s10th,
  input  logic       ylw_nrth_s10th,
  input  logic       grn_nrth_s10th,
  input  logic       red_west_s10th,
  input  logic       ylw_west_s10th,
  input  logic       grn_west_s10th,
  input  logic       red_nrth_s11th,
  input  logic       ylw_nrth_s11th,
  input  logic       grn_nrth_s11th,
  input  logic       red_west_s11th,
  input  logic       ylw_west_s11th,
  input  logic       grn_west_s11th,
  input  logic       walk_nrth_s10th,
  input  logic       stop_nrth_s10th,
  input  logic       walk_west_s10th,
  input  logic       stop_west_s10th,
  input  logic       walk_nrth_s11th,
  input  logic       stop_nrth_s11th,
  input  logic       walk_west_s11th,
  input  logic       stop_west_s11th,
  input  logic       fault_clear,
  output logic       armed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_src,
  output logic       fault_pulse,
  output logic [7:0] fault_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YLW = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [YLW_CNT_W-1:0] MIN_Y =
    YLW_CNT_W'(MIN_YLW_CYCLES);

  // Triples are {red, ylw, grn}; crossings are {walk, stop}.
  logic [3:0][2:0] veh_d;
  logic [3:0][1:0] ped_d;

  assign veh_d = {
    {red_west_s11th, ylw_west_s11th, grn_west_s11th},
    {red_nrth_s11th, ylw_nrth_s11th, grn_nrth_s11th},
    {red_west_s10th, ylw_west_s10th, grn_west_s10th},
    {red_nrth_s10th, ylw_nrth_s10th, grn_nrth_s10th}
  };

  assign ped_d = {
    {walk_west_s11th, stop_west_s11th},
    {walk_nrth_s11th, stop_nrth_s11th},
    {walk_west_s10th, stop_west_s10th},
    {walk_nrth_s10th, stop_nrth_s10th}
  };

  logic [3:0][2:0] veh_cur;
  logic [3:0][2:0] veh_prev;
  logic [3:0][1:0] ped_cur;
  logic [YLW_CNT_W-1:0] ylw_cnt [4];

  // Crossing checks look only at the current sample, so no
  // previous copy of the crossing lamps is kept.
  always_ff @(posedge clk_50_mhz or posedge reset) begin
    if (reset) begin
      veh_cur  <= '0;
      veh_prev <= '0;
      ped_cur  <= '0;
    end else begin
      veh_cur  <= veh_d;
      veh_prev <= veh_cur;
      ped_cur  <= ped_d;
    end
  end

  always_ff @(posedge clk_50_mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) ylw_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (veh_cur[i][1] && !veh_prev[i][1])
          ylw_cnt[i] <= YLW_CNT_W'(1);
        else if (veh_cur[i][1]) begin
          if (ylw_cnt[i] < MIN_Y)
            ylw_cnt[i] <= ylw_cnt[i] + YLW_CNT_W'(1);
        end else
          ylw_cnt[i] <= '0;
      end
    end
  end

  logic [6:1][3:0] viol;
  logic [3:0]      nonred;
  logic            hit;
  logic [2:0]      hit_code;
  logic [1:0]      hit_src;

  always_comb begin
    viol = '0;
    for (int i = 0; i < 4; i++)
      nonred[i] = veh_cur[i][1] | veh_cur[i][0];
    for (int i = 0; i < 4; i++) begin
      logic oh_c;
      logic oh_p;
      logic legal;
      oh_c = $onehot(veh_cur[i]);
      oh_p = $onehot(veh_prev[i]);
      legal = (veh_cur[i] == veh_prev[i]) ||
        (veh_prev[i] == L_RED && veh_cur[i] == L_GRN) ||
        (veh_prev[i] == L_GRN && veh_cur[i] == L_YLW) ||
        (veh_prev[i] == L_YLW && veh_cur[i] == L_RED);
      viol[1][i] = !oh_c;
      viol[3][i] = oh_c && oh_p && !legal;
      viol[4][i] = veh_prev[i] == L_YLW &&
                   veh_cur[i] == L_RED &&
                   ylw_cnt[i] < MIN_Y;
      viol[5][i] = ped_cur[i][1] == ped_cur[i][0];
      // Partner approach at the same intersection is i^1.
      viol[6][i] = ped_cur[i][1] && nonred[i ^ 1];
    end
    viol[2][0] = nonred[0] && nonred[1];
    viol[2][2] = nonred[2] && nonred[3];
  end

  // Scan high to low so the lowest code/index is left standing.
  always_comb begin
    hit      = 1'b0;
    hit_code = 3'd0;
    hit_src  = 2'd0;
    for (int c = 6; c >= 1; c--) begin
      for (int i = 3; i >= 0; i--) begin
        if (viol[c][i]) begin
          hit      = 1'b1;
          hit_code = 3'(c);
          hit_src  = 2'(i);
        end
      end
    end
  end

  state_t state;
  // Low only until the first post-reset edge: prev needs two
  // samples after reset, but only one after a clear.
  logic   warm;

  always_ff @(posedge clk_50_mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      warm        <= 1'b0;
      armed       <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      fault_src   <= 2'd0;
      fault_pulse <= 1'b0;
      fault_cnt   <= 8'd0;
    end else begin
      warm        <= 1'b1;
      fault_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (warm) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        ARMED: begin
          if (hit) begin
            state       <= FAULT;
            armed       <= 1'b0;
            fault       <= 1'b1;
            fault_code  <= hit_code;
            fault_src   <= hit_src;
            fault_pulse <= 1'b1;
            if (fault_cnt != 8'hFF)
              fault_cnt <= fault_cnt + 8'd1;
          end
        end
        FAULT: begin
          if (fault_clear) begin
            state      <= IDLE;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_src  <= 2'd0;
          end
        end
        default: begin
          state <= IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule
